fifo_param: RTL

Parametrised synchronous FIFO with integrated state machine, pointer/count calculation and storage. It generalises the fixed 8-deep, read-or-write FIFO to configurable width and depth, and adds simultaneous read+write and almost-full/almost-empty flags. Per-cycle acknowledge and error outputs let the surrounding datapath use it as a drop-in buffer.

---
 rtl/fifo_param_pkg.sv | 33 +++
 rtl/fifo_param_mem.sv | 32 +++
 rtl/fifo_param.sv | 104 ++++++++++
 3 files changed

// File: rtl/fifo_param_pkg.sv
// Shared state encodings, default parameters and state-decode helpers for fifo_param.
// Latency: n/a. Backpressure: n/a.
package fifo_param_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH   = 3;
  localparam int DEF_AEMPTY_LEVEL = 1;

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_NO_OP    = 3'b001,
    ST_WRITE    = 3'b010,
    ST_WR_ERROR = 3'b011,
    ST_READ     = 3'b100,
    ST_RD_ERROR = 3'b101,
    ST_RW       = 3'b110,
    ST_WR_RDERR = 3'b111
  } state_t;

  function automatic int def_afull(input int addr_width);
    return (1 << addr_width) - 1;
  endfunction

  // Entering one of these states commits a write / a read respectively.
  function automatic logic st_wr_ok(input state_t s);
    return (s == ST_WRITE) || (s == ST_RW) || (s == ST_WR_RDERR);
  endfunction

  function automatic logic st_rd_ok(input state_t s);
    return (s == ST_READ) || (s == ST_RW);
  endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write, registered read, storage not reset.
// Latency: read data one edge after i_re. Backpressure: none, caller guards addresses.
module fifo_param_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_dout
);

  logic [DATA_WIDTH-1:0] r_mem [1 << ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_din;
  end

  // Same-address read+write returns the old word, which is the oldest entry on a full RW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_dout <= '0;
    else if (i_re) r_dout <= r_mem[i_raddr];
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with 3-bit request-result state machine, flags and ack/err.
// Latency: one edge for data, count, flags and ack/err; overflow/underflow reported via wr_err/rd_err, never stalls.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int AFULL_LEVEL  = def_afull(ADDR_WIDTH),
  parameter int AEMPTY_LEVEL = DEF_AEMPTY_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_head;
  logic [ADDR_WIDTH-1:0] r_tail;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_go;
  logic                  w_rd_go;

  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);

  // Both requests on a full FIFO still go to RW: the read frees the slot the write uses.
  always_comb begin
    w_next_state = ST_NO_OP;
    case ({wr_en, rd_en})
      2'b00:   w_next_state = ST_NO_OP;
      2'b10:   w_next_state = w_full  ? ST_WR_ERROR : ST_WRITE;
      2'b01:   w_next_state = w_empty ? ST_RD_ERROR : ST_READ;
      default: w_next_state = w_empty ? ST_WR_RDERR : ST_RW;
    endcase
  end

  assign w_wr_go = st_wr_ok(w_next_state);
  assign w_rd_go = st_rd_ok(w_next_state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_wr_go) r_tail <= r_tail + PTR_ONE;
      if (w_rd_go) r_head <= r_head + PTR_ONE;
      case ({w_wr_go, w_rd_go})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_param_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_we    (w_wr_go),
    .i_waddr (r_tail),
    .i_din   (din),
    .i_re    (w_rd_go),
    .i_raddr (r_head),
    .o_dout  (dout)
  );

  assign data_count   = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);

  assign wr_ack = st_wr_ok(r_state);
  assign wr_err = (r_state == ST_WR_ERROR);
  assign rd_ack = st_rd_ok(r_state);
  assign rd_err = (r_state == ST_RD_ERROR) || (r_state == ST_WR_RDERR);

endmodule
